lsu_dmem_responder: RTL and testbench

- Data-memory responder at the far end of the core's LSU request interface.
- Accepts single-beat requests (mem_en, mem_wen, mem_addr, mem_wdata) from the LSU and services them against an internal word-organised array.
- Writes are performed with byte-lane enables and complete without a response.
- Reads return data with a programmable fixed latency, signalled by a one-cycle mem_rvld pulse. The forwarding/hazard logic in the core relies on that pulse to release its load-use stall.

---
 rtl/lsu_dmem_responder.sv | 119 +++++++++++
 tb/tb_lsu_dmem_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem_responder.sv
// Data-memory responder for the LSU request port: byte-lane writes complete silently,
// reads return after a fixed programmable latency with a one-cycle mem_rvld pulse.
module lsu_dmem_responder #(
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 2
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_rdy,
  output logic [31:0] mem_rdata,
  output logic        mem_rvld,
  output logic        mem_err
);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                oor_q, oor_d;
  logic                rvld_q, rvld_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q;
  logic [31:0]         mem_q [2**ADDR_W];

  logic [ADDR_W-1:0]   req_idx;
  logic                req_oor;
  logic                wr_acc, rd_acc;
  logic                fire;
  logic [ADDR_W-1:0]   sel_idx;
  logic                sel_oor;
  logic                unused_addr_lsb;

  // Byte offset within the word carries no meaning here; misaligned addresses hit the word.
  assign unused_addr_lsb = ^mem_addr[1:0];
  assign req_idx = mem_addr[ADDR_W+1:2];
  assign req_oor = |mem_addr[31:ADDR_W+2];

  assign mem_rdy = (state_q == IDLE);
  assign wr_acc  = mem_en & mem_rdy & (|mem_wen);
  assign rd_acc  = mem_en & mem_rdy & ~(|mem_wen);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    oor_d   = oor_q;
    fire    = 1'b0;
    sel_idx = idx_q;
    sel_oor = oor_q;
    case (state_q)
      IDLE: begin
        if (rd_acc) begin
          idx_d = req_idx;
          oor_d = req_oor;
          cnt_d = 4'(READ_LAT - 1);
          if (READ_LAT == 1) begin
            // Single-cycle latency answers straight from the request fields.
            fire    = 1'b1;
            sel_idx = req_idx;
            sel_oor = req_oor;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          fire    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rvld_d = fire;
    err_d  = (wr_acc & req_oor) | (fire & sel_oor);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      rvld_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      oor_q   <= oor_d;
      rvld_q  <= rvld_d;
      err_q   <= err_d;
      if (fire) rdata_q <= sel_oor ? 32'h0 : mem_q[sel_idx];
    end
  end

  // NOTE: the array has no reset; clearing it would block RAM inference and is not needed.
  always_ff @(posedge CLK) begin
    if (wr_acc && !req_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wen[i]) mem_q[req_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  assign mem_rvld  = rvld_q;
  assign mem_err   = err_q;
  assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_dmem_responder.sv
// Bench for lsu_dmem_responder: three instances (READ_LAT 2, 1, 3) checked every cycle
// against a transaction-level model of memory contents and response timing.
module tb_lsu_dmem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rstn, en, rdy, rvld, err;
  logic [3:0]  wen   [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    lsu_dmem_responder #(
      .ADDR_W  (10),
      .READ_LAT((g == 0) ? 2 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .CLK      (clk),
      .RSTN     (rstn[g]),
      .mem_en   (en[g]),
      .mem_wen  (wen[g]),
      .mem_addr (addr[g]),
      .mem_wdata(wdata[g]),
      .mem_rdy  (rdy[g]),
      .mem_rdata(rdata[g]),
      .mem_rvld (rvld[g]),
      .mem_err  (err[g])
    );
  end

  int          cyc;
  int          npass;
  int          ntotal;

  // Reference model: word contents plus the single outstanding read with its due cycle.
  logic [31:0] mmem    [3][1024];
  bit          pend    [3];
  int          due     [3];
  logic [31:0] pdata   [3];
  bit          poor    [3];
  int          busy    [3];
  int          err_due [3];
  logic [31:0] last_rd [3];

  function automatic int lat(int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 3);
  endfunction

  task automatic chk(string tag, int k, logic [31:0] got, logic [31:0] exp);
    ntotal++;
    assert (got === exp) npass++;
    else $error("FAIL %s dut%0d cyc %0d: got %h expected %h", tag, k, cyc, got, exp);
  endtask

  task automatic model_reset(int k);
    pend[k]    = 1'b0;
    busy[k]    = 0;
    err_due[k] = -1;
    last_rd[k] = 32'h0;
  endtask

  task automatic check_all();
    bit exp_rvld, exp_err, exp_rdy;
    for (int k = 0; k < 3; k++) begin
      exp_rvld = pend[k] && (due[k] == cyc);
      exp_err  = (err_due[k] == cyc) || (exp_rvld && poor[k]);
      exp_rdy  = (cyc >= busy[k]);
      if (exp_rvld) begin
        last_rd[k] = pdata[k];
        pend[k]    = 1'b0;
      end
      chk("rdy",   k, 32'(rdy[k]),  32'(exp_rdy));
      chk("rvld",  k, 32'(rvld[k]), 32'(exp_rvld));
      chk("err",   k, 32'(err[k]),  32'(exp_err));
      chk("rdata", k, rdata[k],     last_rd[k]);
    end
  endtask

  // One clock cycle: check all outputs, present (optional) request on dut d, advance.
  task automatic step(int d, bit e, logic [3:0] w, logic [31:0] a, logic [31:0] wd,
                      output bit acc);
    logic [31:0] mask;
    int          idx;
    bit          oor;
    check_all();
    for (int k = 0; k < 3; k++) begin
      en[k]    = 1'b0;
      wen[k]   = 4'h0;
      addr[k]  = 32'h0;
      wdata[k] = 32'h0;
    end
    en[d] = e; wen[d] = w; addr[d] = a; wdata[d] = wd;
    acc = e && (cyc >= busy[d]);
    if (acc) begin
      idx = int'(a[11:2]);
      oor = (a[31:12] != 20'h0);
      if (w != 4'h0) begin
        if (oor) err_due[d] = cyc + 1;
        else begin
          mask = {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
          mmem[d][idx] = (mmem[d][idx] & ~mask) | (wd & mask);
        end
      end else begin
        pend[d]  = 1'b1;
        due[d]   = cyc + lat(d);
        poor[d]  = oor;
        pdata[d] = oor ? 32'h0 : mmem[d][idx];
        busy[d]  = cyc + lat(d);
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(int n);
    bit acc;
    repeat (n) step(0, 1'b0, 4'h0, 32'h0, 32'h0, acc);
  endtask

  // Hold the request until accepted, bounded so a stuck mem_rdy cannot hang the run.
  task automatic req(int d, logic [3:0] w, logic [31:0] a, logic [31:0] wd);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) step(d, 1'b1, w, a, wd, acc);
    if (!acc) begin
      ntotal++;
      $error("FAIL accept_timeout dut%0d cyc %0d: got no accept expected accept", d, cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int          d;
    logic [31:0] a;
    logic [3:0]  w;
    cyc = 0; npass = 0; ntotal = 0;
    rstn = 3'b000;
    for (int k = 0; k < 3; k++) begin
      en[k] = 1'b0; wen[k] = 4'h0; addr[k] = 32'h0; wdata[k] = 32'h0;
      model_reset(k);
    end
    @(negedge clk);
    @(negedge clk);
    rstn = 3'b111;
    idle(2);

    // Write then read-after-write on the LATENCY=2 instance.
    req(0, 4'hF, 32'h10, 32'hDEADBEEF);
    req(0, 4'h0, 32'h10, 32'h0);
    idle(3);

    // Partial byte-lane update.
    req(0, 4'hF, 32'h20, 32'h11223344);
    req(0, 4'b0101, 32'h20, 32'hAABBCCDD);
    req(0, 4'h0, 32'h20, 32'h0);
    idle(3);

    // Second read held while the first is outstanding.
    req(0, 4'hF, 32'h24, 32'h24242424);
    req(0, 4'h0, 32'h10, 32'h0);
    req(0, 4'h0, 32'h24, 32'h0);
    idle(3);

    // Out-of-range write aliases word 0 in index bits but must not touch it.
    req(0, 4'hF, 32'h0, 32'hCAFEF00D);
    req(0, 4'hF, 32'h1000, 32'h12345678);
    req(0, 4'h0, 32'h0, 32'h0);
    req(0, 4'h0, 32'h1000, 32'h0);
    idle(3);
    req(0, 4'h0, 32'h13, 32'h0);
    idle(3);

    // LATENCY=1: four reads on consecutive cycles.
    for (int i = 0; i < 4; i++) req(1, 4'hF, 32'h30 + 32'(4 * i), 32'hA0B0C000 + 32'(i));
    for (int i = 3; i >= 0; i--) req(1, 4'h0, 32'h30 + 32'(4 * i), 32'h0);
    idle(3);

    // LATENCY=3: reset lands while the read is outstanding.
    req(2, 4'hF, 32'h8, 32'h5A5A1234);
    req(2, 4'h0, 32'h8, 32'h0);
    rstn[2] = 1'b0;
    #1;
    model_reset(2);
    chk("async_rst_rdy",   2, 32'(rdy[2]),  32'h1);
    chk("async_rst_rvld",  2, 32'(rvld[2]), 32'h0);
    chk("async_rst_rdata", 2, rdata[2],     32'h0);
    idle(1);
    rstn[2] = 1'b1;
    idle(6);
    req(2, 4'h0, 32'h8, 32'h0);
    idle(4);

    // Randomized traffic over a pre-seeded window on all three instances.
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 16; i++) req(k, 4'hF, 32'h40 + 32'(4 * i), $urandom);
    for (int n = 0; n < 150; n++) begin
      d = $urandom_range(0, 2);
      a = 32'h40 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = a | (32'($urandom_range(1, 20'hFFFFF)) << 12);
      w = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      if ($urandom_range(0, 5) == 0) idle(1);
      req(d, w, a, $urandom);
    end
    idle(5);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
